// File: rtl/io_bus_pkg.sv
// Shared widths, fixed response words and FSM state encoding for the IO bus fanout.
// The read-timeout feature is enabled by defining IO_FANOUT_TIMEOUT_EN.
package io_bus_pkg;

    localparam int IO_ADDR_W  = 28;
    localparam int IO_DATA_W  = 32;
    localparam int SLV_ADDR_W = 20;

    localparam logic [IO_DATA_W-1:0] UNMAPPED_WORD = 32'hBADA_DD00;
    localparam logic [IO_DATA_W-1:0] TIMEOUT_WORD  = 32'hDEAD_0001;

    typedef logic [1:0] io_state_t;

    localparam io_state_t ST_IDLE = 2'd0;
    localparam io_state_t ST_WAIT = 2'd1;
    localparam io_state_t ST_DONE = 2'd2;

    // A single slave still needs a one-bit index so every vector stays legal.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/io_bus_fanout_decode.sv
// Slave-ID decoder: turns the upper address byte into a hit flag and a slave index.
// Part of io_bus_fanout; optional timeout macro IO_FANOUT_TIMEOUT_EN does not affect it.
module io_addr_decode
    import io_bus_pkg::*;
#(
    parameter int         N_SLAVES = 4,
    parameter logic [7:0] BASE_ID  = 8'h01,
    parameter int         IDX_W    = idx_width(N_SLAVES)
) (
    input  logic [7:0]       id_i,
    output logic             hit_o,
    output logic [IDX_W-1:0] idx_o
);

    // Nine-bit compare so the window end never wraps past 8'hFF.
    localparam logic [8:0] ID_LIMIT = 9'(BASE_ID) + 9'(N_SLAVES);

    if (N_SLAVES < 1 || N_SLAVES > 16 || (32'(BASE_ID) + N_SLAVES) > 256) begin : g_bad_cfg
        $error("io_addr_decode: illegal N_SLAVES/BASE_ID combination");
    end

    always_comb begin
        hit_o = ({1'b0, id_i} >= {1'b0, BASE_ID}) && ({1'b0, id_i} < ID_LIMIT);
        idx_o = IDX_W'(id_i - BASE_ID);
    end

endmodule

// File: rtl/io_bus_fanout.sv
// Fans one upstream IO port out to N_SLAVES slaves and tracks a single outstanding read.
// Define IO_FANOUT_TIMEOUT_EN to compile in the read-ack timeout watchdog.
module io_bus_fanout
    import io_bus_pkg::*;
#(
    parameter int         N_SLAVES = 4,
    parameter logic [7:0] BASE_ID  = 8'h01,
    parameter int         TIMEOUT  = 255
) (
    input  logic                       io_clk,
    input  logic                       reset_n,
    input  logic                       io_sel,
    input  logic                       io_sync,
    input  logic [IO_ADDR_W-1:0]       io_addr,
    input  logic                       io_rd_en,
    input  logic                       io_wr_en,
    input  logic [IO_DATA_W-1:0]       io_wr_data,
    output logic [IO_DATA_W-1:0]       io_rd_data,
    output logic                       io_rd_ack,
    output logic [N_SLAVES-1:0]        slv_sel,
    output logic [SLV_ADDR_W-1:0]      slv_addr,
    output logic                       slv_rd_en,
    output logic                       slv_wr_en,
    output logic [IO_DATA_W-1:0]       slv_wr_data,
    input  logic [N_SLAVES*32-1:0]     slv_rd_data,
    input  logic [N_SLAVES-1:0]        slv_rd_ack,
    output logic                       err_unmapped,
    output logic                       err_timeout,
    input  logic                       err_clr
);

    localparam int IDX_W = idx_width(N_SLAVES);

    logic                 hit;
    logic [IDX_W-1:0]     idx;
    logic                 rd_req;
    logic                 sel_ack;
    logic [IO_DATA_W-1:0] sel_data;
    logic                 unm_set;

    io_state_t            state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [IO_DATA_W-1:0] rd_data_q, rd_data_d;
    logic                 err_unm_q, err_unm_d;

`ifdef IO_FANOUT_TIMEOUT_EN
    logic [15:0]          timer_q, timer_d;
    logic                 err_to_q, err_to_d;
    logic                 to_set;

    if (TIMEOUT < 2 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("io_bus_fanout: TIMEOUT out of range");
    end
`endif

    io_addr_decode #(
        .N_SLAVES (N_SLAVES),
        .BASE_ID  (BASE_ID),
        .IDX_W    (IDX_W)
    ) u_decode (
        .id_i  (io_addr[27:20]),
        .hit_o (hit),
        .idx_o (idx)
    );

    // Slave-side strobes are pure functions of the upstream inputs and ignore reset.
    always_comb begin
        for (int i = 0; i < N_SLAVES; i++) begin
            slv_sel[i] = io_sel & hit & (idx == IDX_W'(i));
        end
        slv_addr    = io_addr[SLV_ADDR_W-1:0];
        slv_rd_en   = io_rd_en;
        slv_wr_en   = io_wr_en;
        slv_wr_data = io_wr_data;
    end

    always_comb begin
        sel_ack  = 1'b0;
        sel_data = '0;
        for (int i = 0; i < N_SLAVES; i++) begin
            if (idx_q == IDX_W'(i)) begin
                sel_ack  = slv_rd_ack[i];
                sel_data = slv_rd_data[i*32 +: 32];
            end
        end
    end

    assign rd_req = io_sel & io_sync & io_rd_en;

    // An abort by dropping io_rd_en takes precedence over a same-cycle ack.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        rd_data_d = rd_data_q;
        unm_set   = 1'b0;
`ifdef IO_FANOUT_TIMEOUT_EN
        timer_d   = timer_q;
        to_set    = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (rd_req && hit) begin
                    idx_d   = idx;
`ifdef IO_FANOUT_TIMEOUT_EN
                    timer_d = '0;
`endif
                    state_d = ST_WAIT;
                end else if (rd_req) begin
                    rd_data_d = UNMAPPED_WORD;
                    unm_set   = 1'b1;
                    state_d   = ST_DONE;
                end
                if (io_sel && io_wr_en && !hit) begin
                    unm_set = 1'b1;
                end
            end
            ST_WAIT: begin
                if (!io_rd_en) begin
                    state_d = ST_IDLE;
                end else if (sel_ack) begin
                    rd_data_d = sel_data;
                    state_d   = ST_DONE;
                end
`ifdef IO_FANOUT_TIMEOUT_EN
                else if (timer_q == 16'(TIMEOUT - 1)) begin
                    rd_data_d = TIMEOUT_WORD;
                    to_set    = 1'b1;
                    state_d   = ST_DONE;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
`endif
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Sticky flags: a new error in the same cycle as err_clr keeps the flag set.
    always_comb begin
        err_unm_d = (err_unm_q & ~err_clr) | unm_set;
`ifdef IO_FANOUT_TIMEOUT_EN
        err_to_d  = (err_to_q & ~err_clr) | to_set;
`endif
    end

    always_ff @(posedge io_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            rd_data_q <= '0;
            err_unm_q <= 1'b0;
`ifdef IO_FANOUT_TIMEOUT_EN
            timer_q   <= '0;
            err_to_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            rd_data_q <= rd_data_d;
            err_unm_q <= err_unm_d;
`ifdef IO_FANOUT_TIMEOUT_EN
            timer_q   <= timer_d;
            err_to_q  <= err_to_d;
`endif
        end
    end

    assign io_rd_data   = rd_data_q;
    assign io_rd_ack    = (state_q == ST_DONE);
    assign err_unmapped = err_unm_q;
`ifdef IO_FANOUT_TIMEOUT_EN
    assign err_timeout  = err_to_q;
`else
    assign err_timeout  = 1'b0;
`endif

endmodule

// File: tb/tb_io_bus_fanout.sv
// Self-checking bench for io_bus_fanout: decode vector table, directed read scenarios
// and randomized reads against a cycle-count reference model.
module tb_io_bus_fanout;
    import io_bus_pkg::*;

    localparam int         NS  = 4;
    localparam logic [7:0] BID = 8'h01;
    localparam int         TMO = 8;
`ifdef IO_FANOUT_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic           io_clk;
    logic           reset_n;
    logic           io_sel, io_sync, io_rd_en, io_wr_en, err_clr;
    logic [27:0]    io_addr;
    logic [31:0]    io_wr_data;
    logic [31:0]    io_rd_data;
    logic           io_rd_ack;
    logic [NS-1:0]  slv_sel;
    logic [19:0]    slv_addr;
    logic           slv_rd_en, slv_wr_en;
    logic [31:0]    slv_wr_data;
    logic [NS*32-1:0] slv_rd_data;
    logic [NS-1:0]  slv_rd_ack;
    logic           err_unmapped, err_timeout;

    logic [31:0]    slvData [NS];
    logic [31:0]    lastData;
    int             total = 0;
    int             bad   = 0;

    io_bus_fanout #(.N_SLAVES(NS), .BASE_ID(BID), .TIMEOUT(TMO)) dut (
        .io_clk(io_clk), .reset_n(reset_n),
        .io_sel(io_sel), .io_sync(io_sync), .io_addr(io_addr),
        .io_rd_en(io_rd_en), .io_wr_en(io_wr_en), .io_wr_data(io_wr_data),
        .io_rd_data(io_rd_data), .io_rd_ack(io_rd_ack),
        .slv_sel(slv_sel), .slv_addr(slv_addr), .slv_rd_en(slv_rd_en),
        .slv_wr_en(slv_wr_en), .slv_wr_data(slv_wr_data),
        .slv_rd_data(slv_rd_data), .slv_rd_ack(slv_rd_ack),
        .err_unmapped(err_unmapped), .err_timeout(err_timeout), .err_clr(err_clr)
    );

    for (genvar g = 0; g < NS; g++) begin : g_slv
        assign slv_rd_data[g*32 +: 32] = slvData[g];
    end

    initial io_clk = 1'b0;
    always #5 io_clk = ~io_clk;

    typedef struct {
        logic [27:0] addr;
        logic        sel;
        logic        rd;
        logic        wr;
        logic [31:0] wdata;
        logic [3:0]  expSel;
        logic [19:0] expAddr;
    } vec_t;

    vec_t vecs [7];

    task automatic cyc();
        @(posedge io_clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic sel, input logic sync, input logic rd, input logic wr,
                                 input logic [27:0] addr, input logic [31:0] wdata);
        io_sel     = sel;
        io_sync    = sync;
        io_rd_en   = rd;
        io_wr_en   = wr;
        io_addr    = addr;
        io_wr_data = wdata;
    endtask

    task automatic clearBus();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 28'h0, 32'h0);
        slv_rd_ack = '0;
        err_clr    = 1'b0;
    endtask

    task automatic clearErr(input string tag);
        err_clr = 1'b1;
        cyc();
        err_clr = 1'b0;
        checkOutput({tag, " err_unmapped cleared"}, 32'(err_unmapped), 32'd0);
        checkOutput({tag, " err_timeout cleared"}, 32'(err_timeout), 32'd0);
    endtask

    task automatic randomizeSlaves();
        for (int i = 0; i < NS; i++) begin
            slvData[i] = {4'(i), 28'($urandom)};
        end
    endtask

    // Reference: unmapped reads answer one cycle after the request; a mapped read whose slave
    // acks d cycles into WAIT answers at cycle d+2; with the watchdog the latest answer is at
    // cycle TMO+1 carrying the timeout word. Zero means no answer within the limit.
    task automatic doRead(input logic [27:0] addr, input int delay, input logic [NS-1:0] noise,
                          input bit holdSync, input int limit, input string tag);
        logic [7:0]    id;
        bit            mapped;
        int            slot;
        int            expN, gotN;
        logic [31:0]   expData;
        bit            expTo;
        logic [NS-1:0] tgt;
        id     = addr[27:20];
        mapped = (int'(id) >= int'(BID)) && (int'(id) < int'(BID) + NS);
        slot   = int'(id) - int'(BID);
        tgt    = '0;
        if (mapped) tgt[slot] = 1'b1;
        if (!mapped) begin
            expN = 1; expData = UNMAPPED_WORD; expTo = 1'b0;
        end else if (TMO_EN && delay > TMO - 1) begin
            expN = TMO + 1; expData = TIMEOUT_WORD; expTo = 1'b1;
        end else if (delay + 2 <= limit) begin
            expN = delay + 2; expData = slvData[slot]; expTo = 1'b0;
        end else begin
            expN = 0; expData = lastData; expTo = 1'b0;
        end

        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, addr, $urandom);
        cyc();
        gotN = 0;
        for (int n = 1; n <= limit; n++) begin
            if (io_rd_ack === 1'b1) begin
                gotN = n;
                break;
            end
            if (!holdSync) io_sync = 1'b0;
            slv_rd_ack = noise & ~tgt;
            if (mapped && (n - 1 == delay)) slv_rd_ack[slot] = 1'b1;
            cyc();
        end
        checkOutput({tag, " ack cycle"}, 32'(gotN), 32'(expN));
        checkOutput({tag, " rd_data"}, io_rd_data, expData);
        checkOutput({tag, " err_unmapped"}, 32'(err_unmapped), 32'(!mapped));
        checkOutput({tag, " err_timeout"}, 32'(err_timeout), 32'(expTo));
        lastData = expData;
        clearBus();
        cyc();
        checkOutput({tag, " ack one cycle"}, 32'(io_rd_ack), 32'd0);
    endtask

    initial begin
        vecs[0] = '{28'h010_0000, 1'b1, 1'b1, 1'b0, 32'h1111_1111, 4'b0001, 20'h0_0000};
        vecs[1] = '{28'h020_0010, 1'b1, 1'b0, 1'b1, 32'h2222_2222, 4'b0010, 20'h0_0010};
        vecs[2] = '{28'h040_ABCD, 1'b1, 1'b1, 1'b0, 32'h3333_3333, 4'b1000, 20'h0_ABCD};
        vecs[3] = '{28'h050_0001, 1'b1, 1'b1, 1'b0, 32'h4444_4444, 4'b0000, 20'h0_0001};
        vecs[4] = '{28'h000_1234, 1'b1, 1'b0, 1'b0, 32'h5555_5555, 4'b0000, 20'h0_1234};
        vecs[5] = '{28'h030_FFFF, 1'b0, 1'b1, 1'b0, 32'h6666_6666, 4'b0000, 20'h0_FFFF};
        vecs[6] = '{28'hFF0_0001, 1'b1, 1'b0, 1'b0, 32'h7777_7777, 4'b0000, 20'h0_0001};

        lastData = 32'h0;
        reset_n  = 1'b0;
        clearBus();
        randomizeSlaves();
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 28'h020_0000, 32'h0);
        cyc();
        cyc();
        checkOutput("reset rd_data", io_rd_data, 32'h0);
        checkOutput("reset rd_ack", 32'(io_rd_ack), 32'd0);
        checkOutput("reset err_unmapped", 32'(err_unmapped), 32'd0);
        checkOutput("reset err_timeout", 32'(err_timeout), 32'd0);
        checkOutput("reset slv_sel live", 32'(slv_sel), 32'h2);
        clearBus();
        #4 reset_n = 1'b1;
        cyc();

        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i].sel, 1'b0, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
            #1;
            checkOutput($sformatf("vec%0d slv_sel", i), 32'(slv_sel), 32'(vecs[i].expSel));
            checkOutput($sformatf("vec%0d slv_addr", i), 32'(slv_addr), 32'(vecs[i].expAddr));
            checkOutput($sformatf("vec%0d slv_rd_en", i), 32'(slv_rd_en), 32'(vecs[i].rd));
            checkOutput($sformatf("vec%0d slv_wr_en", i), 32'(slv_wr_en), 32'(vecs[i].wr));
            checkOutput($sformatf("vec%0d slv_wr_data", i), slv_wr_data, vecs[i].wdata);
        end
        clearBus();
        cyc();
        clearErr("init");

        slvData[1] = 32'h1234_5678;
        doRead(28'h020_0010, 3, '0, 1'b0, 50, "mapped read");
        clearErr("mapped read");

        doRead(28'h090_0000, 0, '0, 1'b0, 50, "unmapped read");
        clearErr("unmapped read");

        doRead(28'h030_0000, 100000, '0, 1'b0, 1000, "silent slave");
        clearErr("silent slave");

        slvData[3] = 32'hCAFE_F00D;
        doRead(28'h040_0000, TMO - 1, 4'b0001, 1'b0, 50, "ack at deadline");
        clearErr("ack at deadline");

        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 28'h090_0000, 32'h0);
        cyc();
        clearBus();
        checkOutput("unmapped write flag", 32'(err_unmapped), 32'd1);
        checkOutput("unmapped write no ack", 32'(io_rd_ack), 32'd0);
        cyc();
        checkOutput("unmapped write sticky", 32'(err_unmapped), 32'd1);
        clearErr("unmapped write");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 28'h010_0000, 32'h0);
        cyc();
        checkOutput("mapped write no flag", 32'(err_unmapped), 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 28'h0A0_0000, 32'h0);
        err_clr = 1'b1;
        cyc();
        clearBus();
        checkOutput("set beats clear", 32'(err_unmapped), 32'd1);
        clearErr("set beats clear");

        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 28'h020_0000, 32'h0);
        cyc();
        io_sync = 1'b0;
        cyc();
        cyc();
        io_rd_en = 1'b0;
        cyc();
        slv_rd_ack = 4'b0010;
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("abort no ack %0d", k), 32'(io_rd_ack), 32'd0);
            cyc();
        end
        checkOutput("abort data held", io_rd_data, lastData);
        checkOutput("abort no error", 32'(err_unmapped | err_timeout), 32'd0);
        clearBus();
        cyc();

        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 28'h030_0000, 32'h0);
        cyc();
        io_sync = 1'b0;
        cyc();
        #2 reset_n = 1'b0;
        #1;
        checkOutput("midread reset rd_data", io_rd_data, 32'h0);
        checkOutput("midread reset rd_ack", 32'(io_rd_ack), 32'd0);
        checkOutput("midread reset errors", 32'(err_unmapped | err_timeout), 32'd0);
        #2 reset_n = 1'b1;
        lastData = 32'h0;
        slv_rd_ack = 4'b0100;
        for (int k = 0; k < 5; k++) begin
            cyc();
            checkOutput($sformatf("post reset no ack %0d", k), 32'(io_rd_ack), 32'd0);
        end
        checkOutput("post reset rd_data", io_rd_data, 32'h0);
        clearBus();
        cyc();
        doRead(28'h020_0004, 2, '0, 1'b0, 50, "after reset");
        clearErr("after reset");

        for (int t = 0; t < 40; t++) begin
            logic [7:0] rid;
            randomizeSlaves();
            rid = 8'($urandom_range(0, 6));
            doRead({rid, 20'($urandom)}, $urandom_range(0, 11), NS'($urandom),
                   1'($urandom_range(0, 1)), 50, $sformatf("rand%0d", t));
            clearErr($sformatf("rand%0d", t));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
